run_length_detector: RTL and testbench

- Parametrised Moore-style detector that evaluates a selectable predicate k over an N_IN-bit input word every enabled cycle.
- Asserts z once k has held for run_len consecutive enabled cycles.
- Supports two modes: level (z stays high while the run continues) and retrigger (one-cycle hit every run_len samples).
- Counts detection events for status/interrupt logic. Successor to the fixed 3-input, 3-cycle parity run detector; that configuration is reproducible exactly.

---
 rtl/run_length_detector.sv | 110 +++++++++++
 tb/tb_run_length_detector.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_length_detector.sv
// Run-length detector: raises z once a selectable predicate on w has held for
// run_len consecutive enabled samples, with level/retrigger modes and an event counter.
module run_length_detector #(
  parameter int N_IN  = 3,
  parameter int CNT_W = 4,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N_IN-1:0]  w,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] run_len,
  input  logic             retrigger,
  input  logic             clr_evt,
  output logic             z,
  output logic             z_pulse,
  output logic [CNT_W-1:0] run_cnt,
  output logic [EVT_W-1:0] evt_cnt,
  output logic             evt_ovf
);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             z;
    logic             zp;
  } run_st_t;

  typedef struct packed {
    logic [EVT_W-1:0] cnt;
    logic             ovf;
  } evt_st_t;

  run_st_t run_q, run_d;
  evt_st_t evt_q, evt_d;

  logic             k;
  logic [CNT_W:0]   nxt;
  logic             len_ok;
  logic             hit;
  logic             evt_max;

  always_comb begin
    k = 1'b0;
    case (mode)
      2'b00: k = ^w;
      2'b01: k = ~(^w);
      2'b10: k = &w;
      2'b11: k = |w;
    endcase
  end

  // One extra bit so run_cnt+1 at the top of the range still compares correctly.
  assign nxt     = {1'b0, run_q.cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign len_ok  = (run_len != '0);
  assign hit     = en & k & len_ok & (nxt >= {1'b0, run_len});
  assign evt_max = &evt_q.cnt;

  always_comb begin
    run_d = run_q;
    run_d.zp = 1'b0;
    if (!en) begin
      run_d.cnt = run_q.cnt;
      run_d.z   = run_q.z;
    end else if (!len_ok || !k) begin
      run_d.cnt = '0;
      run_d.z   = 1'b0;
    end else if (!hit) begin
      run_d.cnt = nxt[CNT_W-1:0];
      run_d.z   = 1'b0;
    end else if (!retrigger) begin
      // Level mode saturates at the threshold so a later lower run_len still hits.
      run_d.cnt = run_len;
      run_d.z   = 1'b1;
      run_d.zp  = ~run_q.z;
    end else begin
      run_d.cnt = '0;
      run_d.z   = 1'b1;
      run_d.zp  = 1'b1;
    end
  end

  always_comb begin
    evt_d = evt_q;
    if (clr_evt) begin
      evt_d.cnt = '0;
      evt_d.ovf = 1'b0;
    end else if (run_d.zp) begin
      if (evt_max) evt_d.ovf = 1'b1;
      else         evt_d.cnt = evt_q.cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= '0;
      evt_q <= '0;
    end else begin
      run_q <= run_d;
      evt_q <= evt_d;
    end
  end

  assign z       = run_q.z;
  assign z_pulse = run_q.zp;
  assign run_cnt = run_q.cnt;
  assign evt_cnt = evt_q.cnt;
  assign evt_ovf = evt_q.ovf;

endmodule

// File: tb/tb_run_length_detector.sv
// Randomized + directed bench for run_length_detector; two instances share stimulus
// (EVT_W=8 and EVT_W=2) and are compared against a behavioural model every cycle.
module tb_run_length_detector;
  localparam int N_IN = 3;
  localparam int CNT_W = 4;

  logic             clk, reset, en, retrigger, clr_evt;
  logic [N_IN-1:0]  w;
  logic [1:0]       mode;
  logic [CNT_W-1:0] run_len;

  logic             z0, zp0, ovf0, z1, zp1, ovf1;
  logic [CNT_W-1:0] rc0, rc1;
  logic [7:0]       ev0;
  logic [1:0]       ev1;

  run_length_detector #(.N_IN(N_IN), .CNT_W(CNT_W), .EVT_W(8)) u_dut (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .run_len(run_len),
    .retrigger(retrigger), .clr_evt(clr_evt), .z(z0), .z_pulse(zp0),
    .run_cnt(rc0), .evt_cnt(ev0), .evt_ovf(ovf0));

  run_length_detector #(.N_IN(N_IN), .CNT_W(CNT_W), .EVT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .run_len(run_len),
    .retrigger(retrigger), .clr_evt(clr_evt), .z(z1), .z_pulse(zp1),
    .run_cnt(rc1), .evt_cnt(ev1), .evt_ovf(ovf1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: run length counted as an integer, events as plain ints.
  int m_run;
  bit m_z, m_zp;
  int m_evt[2];
  bit m_ovf[2];
  int m_max[2] = '{255, 3};

  function automatic bit pred(input logic [N_IN-1:0] v, input logic [1:0] m);
    int ones = $countones(v);
    case (m)
      2'b00:   return (ones % 2) == 1;
      2'b01:   return (ones % 2) == 0;
      2'b10:   return ones == N_IN;
      default: return ones > 0;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_z = 0; m_zp = 0;
    for (int i = 0; i < 2; i++) begin m_evt[i] = 0; m_ovf[i] = 0; end
  endtask

  task automatic model_step();
    bit k = pred(w, mode);
    int len = int'(run_len);
    m_zp = 0;
    if (en) begin
      if (len == 0 || !k) begin
        m_run = 0; m_z = 0;
      end else if (m_run + 1 < len) begin
        m_run = m_run + 1; m_z = 0;
      end else if (!retrigger) begin
        m_run = len; m_zp = !m_z; m_z = 1;
      end else begin
        m_run = 0; m_z = 1; m_zp = 1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (clr_evt) begin
        m_evt[i] = 0; m_ovf[i] = 0;
      end else if (m_zp) begin
        if (m_evt[i] < m_max[i]) m_evt[i]++;
        else m_ovf[i] = 1;
      end
    end
  endtask

  task automatic cmp_all();
    chk("run_cnt", int'(rc0), m_run);
    chk("z", int'(z0), int'(m_z));
    chk("z_pulse", int'(zp0), int'(m_zp));
    chk("evt_cnt", int'(ev0), m_evt[0]);
    chk("evt_ovf", int'(ovf0), int'(m_ovf[0]));
    chk("run_cnt2", int'(rc1), m_run);
    chk("z2", int'(z1), int'(m_z));
    chk("evt_cnt2", int'(ev1), m_evt[1]);
    chk("evt_ovf2", int'(ovf1), int'(m_ovf[1]));
  endtask

  // Called at a negedge; inputs already set by the caller.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_all();
  endtask

  // Asynchronous reset between edges: outputs must clear with no clock.
  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_z", int'(z0), 0);
    chk("rst_evt", int'(ev0), 0);
    cmp_all();
    #1 reset = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] m, input int len, input logic rt);
    mode = m; run_len = CNT_W'(len); retrigger = rt; en = 1'b1; clr_evt = 1'b0;
  endtask

  int exp_rc[5] = '{1, 2, 3, 3, 0};
  int exp_z[5]  = '{0, 0, 1, 1, 0};
  int exp_zp[5] = '{0, 0, 1, 0, 0};
  logic [N_IN-1:0] leg_w[5] = '{3'b111, 3'b100, 3'b010, 3'b111, 3'b110};

  initial begin
    reset = 1'b1; en = 1'b0; w = '0; mode = '0; run_len = '0;
    retrigger = 1'b0; clr_evt = 1'b0;
    model_reset();
    #12 reset = 1'b0;

    // Legacy 3-input odd-parity, length-3 level detector
    do_reset();
    set_cfg(2'b00, 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      w = leg_w[i];
      cycle();
      chk("leg_rc", int'(rc0), exp_rc[i]);
      chk("leg_z", int'(z0), exp_z[i]);
      chk("leg_zp", int'(zp0), exp_zp[i]);
    end
    chk("leg_evt", int'(ev0), 1);

    // Retrigger, run_len=2, all-ones
    do_reset();
    set_cfg(2'b10, 2, 1'b1);
    w = 3'b111;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rt_z", int'(z0), i % 2);
      chk("rt_rc", int'(rc0), (i + 1) % 2);
    end
    chk("rt_evt", int'(ev0), 3);

    // Level mode with enable gaps
    do_reset();
    set_cfg(2'b11, 3, 1'b0);
    w = 3'b001;
    cycle(); cycle();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = N_IN'($urandom);
      cycle();
      chk("hold_rc", int'(rc0), 2);
      chk("hold_z", int'(z0), 0);
    end
    en = 1'b1; w = 3'b001;
    cycle();
    chk("resume_z", int'(z0), 1);

    // Async reset while z=1 and evt_cnt=5
    do_reset();
    set_cfg(2'b11, 1, 1'b1);
    w = 3'b010;
    for (int i = 0; i < 5; i++) cycle();
    chk("pre_evt", int'(ev0), 5);
    chk("pre_z", int'(z0), 1);
    do_reset();
    set_cfg(2'b11, 3, 1'b0);
    cycle(); cycle();
    chk("post_rst_z2", int'(z0), 0);
    cycle();
    chk("post_rst_z3", int'(z0), 1);

    // Saturation on the EVT_W=2 instance, then clear coincident with a hit
    do_reset();
    set_cfg(2'b11, 1, 1'b1);
    w = 3'b100;
    for (int i = 0; i < 5; i++) cycle();
    chk("sat_evt", int'(ev1), 3);
    chk("sat_ovf", int'(ovf1), 1);
    clr_evt = 1'b1;
    cycle();
    chk("clr_evt", int'(ev1), 0);
    chk("clr_ovf", int'(ovf1), 0);
    chk("clr_zp", int'(zp1), 1);
    clr_evt = 1'b0;

    // run_len=0 disables, then run_len=4
    do_reset();
    set_cfg(2'b11, 0, 1'b0);
    w = 3'b111;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("len0_z", int'(z0), 0);
      chk("len0_rc", int'(rc0), 0);
    end
    run_len = 4'd4;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("len4_z", int'(z0), (i == 3) ? 1 : 0);
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 9) == 0) run_len = CNT_W'($urandom_range(0, 5));
        if ($urandom_range(0, 11) == 0) mode = 2'($urandom);
        if ($urandom_range(0, 15) == 0) retrigger = 1'($urandom);
        if ($urandom_range(0, 19) == 0) run_len = CNT_W'($urandom_range(12, 15));
        en = ($urandom_range(0, 99) < 85);
        clr_evt = ($urandom_range(0, 99) < 3);
        // Bias toward long predicate runs
        if ($urandom_range(0, 3) == 0) w = N_IN'($urandom);
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
